// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// State encoding, UART register map and status bit index.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_INIT  = 3'd1,
        S_IDLE  = 3'd2,
        S_POLL  = 3'd3,
        S_CHECK = 3'd4,
        S_WRITE = 3'd5
    } state_t;

    localparam logic [1:0] UART_ODR = 2'd0;
    localparam logic [1:0] UART_IDR = 2'd1;
    localparam logic [1:0] UART_BSR = 2'd2;
    localparam logic [1:0] UART_SR  = 2'd3;

    localparam int SR_BUSY = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr_i.
// Ports: req_i, ptr_i, mask_i (lock mask) in; one-hot grant_o out.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic [N-1:0]  mask_i,
    output logic [N-1:0]  grant_o
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr_i) + i) % N);
            if (!found && req_i[idx] && mask_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters, round-robin.
// Ports: clk_i/rst_i; req_valid_i/req_data_i/req_last_i in, req_ready_o,
// grant_o, busy_o out; UART bus uart_sel_o/we_o/addr_o/data_o, uart_data_i.
// Optional macro UART_ARB_LOCK_EN: hold the grant until req_last_i.
module uart_tx_arbiter #(
    parameter int          NUM_REQ  = 4,
    parameter logic [31:0] BAUD_DIV = 32'd2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o,
    output logic                 uart_sel_o,
    output logic                 uart_we_o,
    output logic [1:0]           uart_addr_o,
    output logic [31:0]          uart_data_o,
    input  logic [31:0]          uart_data_i
);

    import uart_arb_pkg::*;

    localparam int PW = $clog2(NUM_REQ);

    state_t               state;
    state_t               state_nx;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        cur_idx;
    logic [PW-1:0]        win_idx;
    logic [7:0]           byte_q;
    logic [NUM_REQ-1:0]   win;
    logic [NUM_REQ-1:0]   mask;
    logic                 accept;
    logic                 unused_bits;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req_i   (req_valid_i),
        .ptr_i   (ptr),
        .mask_i  (mask),
        .grant_o (win)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) win_idx = PW'(i);
        end
    end

    assign accept      = (state == S_IDLE) && (|win);
    assign req_ready_o = (state == S_IDLE) ? win : '0;
    assign busy_o      = (state != S_IDLE);

`ifdef UART_ARB_LOCK_EN
    // cur_idx still names the lock owner: it only changes on acceptance.
    logic lock_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
        end else if (accept) begin
            lock_q <= ~req_last_i[win_idx];
        end
    end

    assign mask        = lock_q ? (NUM_REQ'(1) << cur_idx) : '1;
    assign unused_bits = ^uart_data_i[31:1];
`else
    assign mask        = '1;
    assign unused_bits = ^{uart_data_i[31:1], req_last_i};
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            S_RST:   state_nx = S_INIT;
            S_INIT:  state_nx = S_IDLE;
            S_IDLE:  state_nx = accept ? S_POLL : S_IDLE;
            S_POLL:  state_nx = S_CHECK;
            S_CHECK: state_nx = uart_data_i[SR_BUSY] ? S_POLL : S_WRITE;
            S_WRITE: state_nx = S_IDLE;
            default: state_nx = S_RST;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_RST;
            ptr     <= PW'(NUM_REQ - 1);
            cur_idx <= '0;
            byte_q  <= '0;
            grant_o <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                byte_q  <= req_data_i[8*win_idx +: 8];
                cur_idx <= win_idx;
                grant_o <= win;
            end
            if (state == S_WRITE) begin
                grant_o <= '0;
                ptr     <= cur_idx;
            end
        end
    end

    always_comb begin
        uart_sel_o  = 1'b0;
        uart_we_o   = 1'b0;
        uart_addr_o = '0;
        uart_data_o = '0;
        unique case (state)
            S_INIT: begin
                uart_sel_o  = 1'b1;
                uart_we_o   = 1'b1;
                uart_addr_o = UART_BSR;
                uart_data_o = BAUD_DIV;
            end
            S_POLL: begin
                uart_sel_o  = 1'b1;
                uart_addr_o = UART_SR;
            end
            S_WRITE: begin
                uart_sel_o  = 1'b1;
                uart_we_o   = 1'b1;
                uart_addr_o = UART_ODR;
                uart_data_o = {24'h0, byte_q};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a simple UART model.
// Byte order comes from a byte-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int          N    = 4;
    localparam logic [31:0] BAUD = 32'd2;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic [N-1:0]   req_valid_i;
    logic [8*N-1:0] req_data_i;
    logic [N-1:0]   req_last_i;
    logic [N-1:0]   req_ready_o;
    logic [N-1:0]   grant_o;
    logic           busy_o;
    logic           uart_sel_o;
    logic           uart_we_o;
    logic [1:0]     uart_addr_o;
    logic [31:0]    uart_data_o;
    logic [31:0]    uart_data_i = '0;

    always #5 clk_i = ~clk_i;

    uart_tx_arbiter #(
        .NUM_REQ  (N),
        .BAUD_DIV (BAUD)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .uart_sel_o  (uart_sel_o),
        .uart_we_o   (uart_we_o),
        .uart_addr_o (uart_addr_o),
        .uart_data_o (uart_data_o),
        .uart_data_i (uart_data_i)
    );

    int total = 0;
    int bad   = 0;
    int n_rd  = 0;
    int n_odr = 0;
    int n_baud = 0;
    int rd_busy_until = 0;
    int tx_len = 1;
    int busy_cnt = 0;
    bit seen_idle = 1'b0;

    logic [7:0] dq[N][$];
    bit         lq[N][$];
    logic [7:0] exp_q[$];
    int         m_ptr = N - 1;
    bit         m_lock = 1'b0;
    int         m_lock_idx = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // UART model: status read data registered one cycle after the read,
    // busy for tx_len cycles after an ODR write, plus forced busy reads.
    always @(posedge clk_i) begin
        bit rbusy;
        rbusy = 1'b0;
        if (uart_sel_o && !uart_we_o && uart_addr_o == 2'd3) begin
            rbusy = (busy_cnt > 0) || (n_rd < rd_busy_until);
            uart_data_i <= {31'b0, rbusy};
            n_rd++;
            if (!rbusy) seen_idle = 1'b1;
        end
        if (uart_sel_o && uart_we_o && uart_addr_o == 2'd0) begin
            busy_cnt  = tx_len;
            seen_idle = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
    end

    always @(negedge clk_i) begin
        if (uart_sel_o && uart_we_o) begin
            if (uart_addr_o == 2'd0) begin
                chk("odr_after_idle_read", 32'(seen_idle), 32'd1);
                chk("odr_uart_idle", 32'(busy_cnt == 0), 32'd1);
                chk("odr_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    chk("odr_data", uart_data_o, {24'h0, exp_q.pop_front()});
                n_odr++;
            end else if (uart_addr_o == 2'd2) begin
                chk("baud_data", uart_data_o, BAUD);
                n_baud++;
            end else begin
                chk("wr_addr", 32'(uart_addr_o), 32'd0);
            end
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_heads;
        for (int k = 0; k < N; k++) begin
            if (dq[k].size() > 0) begin
                req_valid_i[k]       = 1'b1;
                req_data_i[8*k +: 8] = dq[k][0];
                req_last_i[k]        = lq[k][0];
            end else begin
                req_valid_i[k]       = 1'b0;
                req_data_i[8*k +: 8] = 8'h00;
                req_last_i[k]        = 1'b0;
            end
        end
    endtask

    task automatic pop_req(input int k);
        void'(dq[k].pop_front());
        void'(lq[k].pop_front());
    endtask

    // Byte-level arbitration: who sends next, given all pending queues.
    task automatic model_fill;
        logic [7:0] dc[N][$];
        bit         lc[N][$];
        int         w;
        int         c;
        bit         any;
        for (int k = 0; k < N; k++) begin
            dc[k] = dq[k];
            lc[k] = lq[k];
        end
        for (int s = 0; s < 256; s++) begin
            any = 1'b0;
            for (int k = 0; k < N; k++) if (dc[k].size() > 0) any = 1'b1;
            if (!any) break;
            w = -1;
            if (m_lock && dc[m_lock_idx].size() > 0) begin
                w = m_lock_idx;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    c = (m_ptr + i) % N;
                    if (w < 0 && dc[c].size() > 0) w = c;
                end
            end
            exp_q.push_back(dc[w].pop_front());
`ifdef UART_ARB_LOCK_EN
            m_lock     = !lc[w][0];
            m_lock_idx = w;
`endif
            void'(lc[w].pop_front());
            m_ptr = w;
        end
    endtask

    task automatic run_batch(input bit use_model, input string tag);
        logic [N-1:0] acc;
        bit           done;
        bit           any;
        if (use_model) model_fill();
        done = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            drive_heads();
            @(negedge clk_i);
            acc = req_ready_o & req_valid_i;
            if (req_ready_o != '0)
                chk({tag, "_ready_onehot"},
                    32'($countones(req_ready_o) == 1), 32'd1);
            @(posedge clk_i);
            #1;
            for (int k = 0; k < N; k++) if (acc[k]) pop_req(k);
            any = 1'b0;
            for (int k = 0; k < N; k++) if (dq[k].size() > 0) any = 1'b1;
            done = !any && exp_q.size() == 0 && !busy_o;
        end
        chk({tag, "_complete"}, 32'(done), 32'd1);
        drive_heads();
    endtask

    initial begin
        int rd0;
        int o0;
        int b0;
        int n;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;

        rst_i = 1'b1;
        repeat (3) tick();
        chk("rst_sel", 32'(uart_sel_o), 32'd0);
        chk("rst_we", 32'(uart_we_o), 32'd0);
        chk("rst_addr", 32'(uart_addr_o), 32'd0);
        chk("rst_data", uart_data_o, 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd1);

        rst_i = 1'b0;
        tick();
        chk("init_sel", 32'(uart_sel_o), 32'd1);
        chk("init_we", 32'(uart_we_o), 32'd1);
        chk("init_addr", 32'(uart_addr_o), 32'd2);
        chk("init_data", uart_data_o, BAUD);
        chk("init_ready", 32'(req_ready_o), 32'd0);
        tick();
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_sel", 32'(uart_sel_o), 32'd0);
        chk("baud_once", 32'(n_baud), 32'd1);

        // single byte timing, idle UART
        tx_len = 1;
        dq[1].push_back(8'h55);
        lq[1].push_back(1'b1);
        exp_q.push_back(8'h55);
        m_ptr = 1;
        drive_heads();
        #1;
        chk("t1_ready", 32'(req_ready_o), 32'h2);
        tick();
        pop_req(1);
        drive_heads();
        chk("t1_rd_sel", 32'(uart_sel_o), 32'd1);
        chk("t1_rd_we", 32'(uart_we_o), 32'd0);
        chk("t1_rd_addr", 32'(uart_addr_o), 32'd3);
        chk("t1_grant", 32'(grant_o), 32'h2);
        chk("t1_busy", 32'(busy_o), 32'd1);
        chk("t1_ready_low", 32'(req_ready_o), 32'd0);
        tick();
        chk("t1_chk_sel", 32'(uart_sel_o), 32'd0);
        tick();
        chk("t1_wr_sel", 32'(uart_sel_o), 32'd1);
        chk("t1_wr_we", 32'(uart_we_o), 32'd1);
        chk("t1_wr_addr", 32'(uart_addr_o), 32'd0);
        chk("t1_wr_data", uart_data_o, 32'h55);
        tick();
        chk("t1_idle", 32'(busy_o), 32'd0);
        chk("t1_grant_clr", 32'(grant_o), 32'd0);
        repeat (3) tick();

        // five busy polls before the write
        dq[3].push_back(8'h3C);
        lq[3].push_back(1'b1);
        rd0 = n_rd;
        o0  = n_odr;
        rd_busy_until = n_rd + 5;
        run_batch(1'b1, "poll5");
        chk("poll5_reads", 32'(n_rd - rd0), 32'd6);
        chk("poll5_writes", 32'(n_odr - o0), 32'd1);

        // reset while in S_CHECK
        dq[0].push_back(8'h77);
        lq[0].push_back(1'b1);
        o0 = n_odr;
        drive_heads();
        #1;
        chk("rc_ready", 32'(req_ready_o), 32'h1);
        tick();
        pop_req(0);
        drive_heads();
        tick();
        chk("rc_in_check_sel", 32'(uart_sel_o), 32'd0);
        chk("rc_in_check_grant", 32'(grant_o), 32'h1);
        rst_i = 1'b1;
        tick();
        chk("rc_sel", 32'(uart_sel_o), 32'd0);
        chk("rc_we", 32'(uart_we_o), 32'd0);
        chk("rc_addr", 32'(uart_addr_o), 32'd0);
        chk("rc_data", uart_data_o, 32'd0);
        chk("rc_grant", 32'(grant_o), 32'd0);
        chk("rc_busy", 32'(busy_o), 32'd1);
        tick();
        rst_i = 1'b0;
        b0 = n_baud;
        tick();
        chk("rc_baud_addr", 32'(uart_addr_o), 32'd2);
        chk("rc_baud_we", 32'(uart_we_o), 32'd1);
        repeat (5) tick();
        chk("rc_no_odr", 32'(n_odr - o0), 32'd0);
        chk("rc_baud_again", 32'(n_baud - b0), 32'd1);
        m_ptr  = N - 1;
        m_lock = 1'b0;

        // two streams from a fresh pointer interleave
        dq[0].push_back(8'hA0); lq[0].push_back(1'b1);
        dq[0].push_back(8'hA1); lq[0].push_back(1'b1);
        dq[2].push_back(8'hC0); lq[2].push_back(1'b1);
        dq[2].push_back(8'hC1); lq[2].push_back(1'b1);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hC1);
        m_ptr = 2;
        run_batch(1'b0, "rr");

        // message with last on the third byte, competitor always valid
        dq[0].push_back(8'h10); lq[0].push_back(1'b0);
        dq[0].push_back(8'h11); lq[0].push_back(1'b0);
        dq[0].push_back(8'h12); lq[0].push_back(1'b1);
        dq[1].push_back(8'h20); lq[1].push_back(1'b1);
        run_batch(1'b1, "lock");

        for (int b = 0; b < 8; b++) begin
            tx_len = $urandom_range(1, 25);
            for (int k = 0; k < N; k++) begin
                n = $urandom_range(0, 4);
                for (int j = 0; j < n; j++) begin
                    dq[k].push_back(8'($urandom));
                    lq[k].push_back((j == n - 1) ? 1'b1
                                    : 1'($urandom_range(0, 1)));
                end
            end
            run_batch(1'b1, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
